// File: rtl/pwm_decoder_if.sv
// pwm_decoder bus: one servo PWM line in,
// decoded duty code, raw width and status out.
interface pwm_decoder_if;
  logic        iPwm;
  logic [7:0]  oCode;
  logic [23:0] oWidth;
  logic        oValid;
  logic        oPeriodErr;
  logic        oLost;

  modport master (
    output iPwm,
    input  oCode, oWidth, oValid,
    input  oPeriodErr, oLost
  );

  modport slave (
    input  iPwm,
    output oCode, oWidth, oValid,
    output oPeriodErr, oLost
  );
endinterface

// File: rtl/pwm_decoder.sv
// pwm_decoder: servo PWM capture, measures high
// time and rise-to-rise period, recovers duty code.
module pwm_decoder #(
  parameter logic [23:0] PULSE_MIN  = 24'd80001,
  parameter logic [3:0]  SHIFT      = 4'd12,
  parameter logic [23:0] PERIOD_MIN = 24'd900000,
  parameter logic [23:0] PERIOD_MAX = 24'd1100000,
  parameter logic [23:0] TIMEOUT    = 24'd2000000
) (
  input  logic iClock,
  input  logic iReset,
  pwm_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_RISE,
    HIGH,
    LOW
  } state_e;

  localparam logic [23:0] SAT = 24'd256 << SHIFT;

  state_e      state_q;
  logic        s1_q, s2_q, s3_q;
  logic        rise_q, fall_q;
  logic [23:0] idle_q;
  logic [23:0] wcnt_q, pcnt_q, w_q;
  logic [23:0] width_q;
  logic [7:0]  code_q;
  logic        valid_q, perr_q, lost_q;

  logic [23:0] diff_d;
  logic [7:0]  code_d;
  logic        edge_d, tout_d, in_rng_d;

  function automatic logic [23:0] sat_inc(
    input logic [23:0] v
  );
    return (v == 24'hFFFFFF) ? v : v + 24'd1;
  endfunction

  // Synchronize input and register edge pulses.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= bus.iPwm;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end

  assign edge_d = rise_q | fall_q;
  assign tout_d = (idle_q == TIMEOUT) & ~edge_d;
  assign in_rng_d = (pcnt_q >= PERIOD_MIN) &&
                    (pcnt_q <= PERIOD_MAX);

  // Idle counter: cleared by any edge, sticks at TIMEOUT.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      idle_q <= '0;
    end else if (edge_d) begin
      idle_q <= '0;
    end else if (idle_q != TIMEOUT) begin
      idle_q <= idle_q + 24'd1;
    end
  end

  // Duty code from the latched width, saturated at 255.
  always_comb begin
    diff_d = w_q - PULSE_MIN;
    code_d = 8'd0;
    if (w_q < PULSE_MIN) begin
      code_d = 8'd0;
    end else if (diff_d >= SAT) begin
      code_d = 8'hFF;
    end else begin
      code_d = 8'(diff_d >> SHIFT);
    end
  end

  // Capture FSM with registered result strobes.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= WAIT_RISE;
      wcnt_q  <= '0;
      pcnt_q  <= '0;
      w_q     <= '0;
      width_q <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      if (tout_d) begin
        lost_q  <= 1'b1;
        state_q <= WAIT_RISE;
      end else begin
        unique case (state_q)
          WAIT_RISE: begin
            if (rise_q) begin
              wcnt_q  <= 24'd1;
              pcnt_q  <= 24'd1;
              state_q <= HIGH;
            end
          end
          HIGH: begin
            pcnt_q <= sat_inc(pcnt_q);
            if (fall_q) begin
              w_q     <= wcnt_q;
              state_q <= LOW;
            end else begin
              wcnt_q <= sat_inc(wcnt_q);
            end
          end
          LOW: begin
            if (rise_q) begin
              if (in_rng_d) begin
                width_q <= w_q;
                code_q  <= code_d;
                valid_q <= 1'b1;
                lost_q  <= 1'b0;
              end else begin
                perr_q <= 1'b1;
              end
              wcnt_q  <= 24'd1;
              pcnt_q  <= 24'd1;
              state_q <= HIGH;
            end else begin
              pcnt_q <= sat_inc(pcnt_q);
            end
          end
          default: state_q <= WAIT_RISE;
        endcase
      end
    end
  end

  assign bus.oCode      = code_q;
  assign bus.oWidth     = width_q;
  assign bus.oValid     = valid_q;
  assign bus.oPeriodErr = perr_q;
  assign bus.oLost      = lost_q;

endmodule
